seg_scan: RTL and testbench

- Consumer end of the 48-bit segment bus that the clock, timer and stopwatch blocks produce. Six digits at 8 bits each, active-low; bit 7 of each byte is the decimal point.
- Time-multiplexes the six digits onto one shared active-low segment port and six active-low digit-enable lines.
- Adds frame-synchronous capture, so a display update is never torn mid-frame.
- Adds 8-level brightness PWM and an alarm flash (whole-display blink).
- Sits between the mode-select mux and the FPGA pins.

---
 rtl/seg_scan.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Six-digit, time-multiplexed seven-segment driver. A 48-bit bus of active-low
// segment patterns (bit 7 of each byte is the decimal point) is captured once
// per frame into a shadow register so an update never tears mid-frame. Each
// digit slot lasts SCAN_DIV clocks. The first clock of every slot is blanked to
// avoid ghosting, and the rest of the slot is duty-cycled in eight sub-slots
// for brightness. An alarm flash input blinks the whole display, with the
// visible/blank phase changing only at frame boundaries.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   seg_in     in   [47:0] segment patterns, active-low; [7:0] is digit 0
//   bright     in   [2:0] brightness, 0 = 1/8 duty ... 7 = full duty
//   flash      in   level; while high the whole display blinks
//   an         out  [5:0] digit enables, active-low, at most one low
//   seg        out  [7:0] shared segment lines, active-low
//   frame_tick out  one-cycle pulse marking the start of each frame
// -----------------------------------------------------------------------------
module seg_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int FLASH_FRAMES = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] seg_in,
    input  logic [2:0]  bright,
    input  logic        flash,
    output logic [5:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW:0]   SUB_LEN    = (DW + 1)'(SCAN_DIV / 8);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    // Byte of the shadow belonging to digit idx; unreachable idx shows blank.
    function automatic logic [7:0] digit_sel(input logic [47:0] pat, input logic [2:0] idx);
        logic [7:0] res;
        case (idx)
            3'd0:    res = pat[7:0];
            3'd1:    res = pat[15:8];
            3'd2:    res = pat[23:16];
            3'd3:    res = pat[31:24];
            3'd4:    res = pat[39:32];
            3'd5:    res = pat[47:40];
            default: res = 8'hFF;
        endcase
        return res;
    endfunction

    // One-hot-low enable for digit idx; unreachable idx enables nothing.
    function automatic logic [5:0] digit_en(input logic [2:0] idx);
        logic [5:0] res;
        case (idx)
            3'd0:    res = 6'b111110;
            3'd1:    res = 6'b111101;
            3'd2:    res = 6'b111011;
            3'd3:    res = 6'b110111;
            3'd4:    res = 6'b101111;
            3'd5:    res = 6'b011111;
            default: res = 6'b111111;
        endcase
        return res;
    endfunction

    logic [DW-1:0] div_q,        div_d;
    logic [2:0]    idx_q,        idx_d;
    logic [47:0]   shadow_q,     shadow_d;
    logic [2:0]    bright_q,     bright_d;
    logic [FW-1:0] flash_cnt_q,  flash_cnt_d;
    logic          flash_vis_q,  flash_vis_d;
    logic [5:0]    an_q,         an_d;
    logic [7:0]    seg_q,        seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_start_s;
    logic          frame_start_s;
    logic [DW:0]   lim_s;
    logic          lit_s;

    // Next-state logic for counters, frame capture, flash phase and outputs.
    always_comb begin
        div_d        = div_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        bright_d     = bright_q;
        flash_cnt_d  = flash_cnt_q;
        flash_vis_d  = flash_vis_q;
        frame_tick_d = 1'b0;
        an_d         = 6'b111111;
        seg_d        = 8'hFF;

        slot_start_s  = (div_q == {DW{1'b0}});
        frame_start_s = slot_start_s && (idx_q == 3'd0);

        if (div_q == DIV_LAST) begin
            div_d = {DW{1'b0}};
            if (idx_q >= 3'd5) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            div_d = div_q + DW'(1);
            idx_d = idx_q;
        end

        // Brightness is only re-sampled at slot start so a slot never changes duty midway.
        if (slot_start_s) begin
            bright_d = bright;
        end else begin
            bright_d = bright_q;
        end

        if (frame_start_s) begin
            shadow_d     = seg_in;
            frame_tick_d = 1'b1;
            if (!flash) begin
                flash_cnt_d = {FW{1'b0}};
                flash_vis_d = 1'b1;
            end else if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d = {FW{1'b0}};
                flash_vis_d = ~flash_vis_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FW'(1);
            end
        end else begin
            shadow_d     = shadow_q;
            frame_tick_d = 1'b0;
        end

        // sub <= bright_q is the same as div < (bright_q + 1) * sub-slot length.
        lim_s = SUB_LEN * ({{(DW - 2){1'b0}}, bright_q} + (DW + 1)'(1));
        lit_s = !slot_start_s && ({1'b0, div_q} < lim_s) && flash_vis_q;

        if (lit_s) begin
            an_d  = digit_en(idx_q);
            seg_d = digit_sel(shadow_q, idx_q);
        end else begin
            an_d  = 6'b111111;
            seg_d = 8'hFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= {DW{1'b0}};
            idx_q        <= 3'd0;
            shadow_q     <= 48'hFFFF_FFFF_FFFF;
            bright_q     <= 3'd0;
            flash_cnt_q  <= {FW{1'b0}};
            flash_vis_q  <= 1'b1;
            an_q         <= 6'b111111;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            bright_q     <= bright_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_vis_q  <= flash_vis_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan
// Directed bench for seg_scan with SCAN_DIV=16 (2-cycle sub-slots) and
// FLASH_FRAMES=2. Each frame is walked sample by sample; the expected an/seg/
// frame_tick for every (slot, div) position comes from the pattern, brightness
// and visibility the bench itself chose for that frame.
// -----------------------------------------------------------------------------
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] seg_in;
    logic [2:0]  bright;
    logic        flash;
    logic [5:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] PAT1 = 48'h05_14_23_32_41_50;
    localparam logic [47:0] PAT2 = 48'hA1_B2_C3_D4_E5_F6;
    localparam logic [47:0] PAT3 = 48'h7E_30_6D_79_33_5B;

    always #5 clk = ~clk;

    seg_scan #(
        .SCAN_DIV    (16),
        .FLASH_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .bright     (bright),
        .flash      (flash),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int s, input int d,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s slot=%0d div=%0d got=%h exp=%h", tag, s, d, got, exp);
        end
    endtask

    // Walk one whole frame starting from the frame-start edge. An optional
    // action is applied after the sample at (act_slot, div 4):
    //   1 = drive seg_in, 2 = drive bright (later slots use the new duty),
    //   3 = drive flash.
    task automatic check_frame(input logic [47:0] pat, input logic [2:0] br_a,
                               input logic vis, input int act_slot,
                               input int act_kind, input logic [47:0] act_val);
        logic [2:0] br;
        logic       lit;
        logic [5:0] en;
        logic [7:0] e_an;
        logic [7:0] e_seg;
        logic [7:0] e_ft;
        for (int s = 0; s < 6; s++) begin
            for (int d = 0; d < 16; d++) begin
                tick();
                br    = (act_kind == 2 && s > act_slot) ? act_val[2:0] : br_a;
                lit   = vis && (d != 0) && (d < 2 * (int'(br) + 1));
                en    = ~(6'b000001 << s);
                e_an  = lit ? {2'b00, en} : 8'h3F;
                e_seg = lit ? pat[8*s +: 8] : 8'hFF;
                e_ft  = (s == 0 && d == 0) ? 8'h01 : 8'h00;
                chk("an", s, d, {2'b00, an}, e_an);
                chk("seg", s, d, seg, e_seg);
                chk("frame_tick", s, d, {7'd0, frame_tick}, e_ft);
                if (s == act_slot && d == 4) begin
                    case (act_kind)
                        1:       seg_in = act_val;
                        2:       bright = act_val[2:0];
                        3:       flash  = act_val[0];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        seg_in = 48'h0000_0000_0000;
        bright = 3'd7;
        flash  = 1'b0;

        // Outputs held blank throughout reset.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_an", -1, k, {2'b00, an}, 8'h3F);
            chk("rst_seg", -1, k, seg, 8'hFF);
            chk("rst_ft", -1, k, {7'd0, frame_tick}, 8'h00);
        end
        rst = 1'b0;
        chk("rel_an", -1, 0, {2'b00, an}, 8'h3F);
        chk("rel_seg", -1, 0, seg, 8'hFF);

        // The first post-reset cycle is a frame start and captures seg_in (all
        // zero), so frame 0 lights every segment; PAT1 arrives mid-frame and
        // must not show until the next frame.
        check_frame(48'h0000_0000_0000, 3'd7, 1'b1, 1, 1, PAT1);

        // Scan order with PAT1; PAT2 arrives while digit 2 is being shown.
        check_frame(PAT1, 3'd7, 1'b1, 2, 1, PAT2);
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);

        // Brightness levels, then a mid-slot change from 3 to 7 in slot 1.
        bright = 3'd0;
        check_frame(PAT2, 3'd0, 1'b1, 7, 0, 48'd0);
        bright = 3'd3;
        check_frame(PAT2, 3'd3, 1'b1, 7, 0, 48'd0);
        check_frame(PAT2, 3'd3, 1'b1, 1, 2, 48'd7);

        // Flash: phase changes every second frame start.
        flash = 1'b1;
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);
        check_frame(PAT2, 3'd7, 1'b0, 7, 0, 48'd0);
        check_frame(PAT2, 3'd7, 1'b0, 7, 0, 48'd0);
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);
        // Drop flash during a blank frame: stays blank until the next frame.
        check_frame(PAT2, 3'd7, 1'b0, 3, 3, 48'd0);
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);

        // Re-arm flash: one visible frame, then a blank one interrupted by reset.
        flash = 1'b1;
        check_frame(PAT2, 3'd7, 1'b1, 7, 0, 48'd0);
        for (int k = 0; k < 69; k++) begin
            tick();
            chk("blank_an", k / 16, k % 16, {2'b00, an}, 8'h3F);
            chk("blank_seg", k / 16, k % 16, seg, 8'hFF);
            chk("blank_ft", k / 16, k % 16, {7'd0, frame_tick}, (k == 0) ? 8'h01 : 8'h00);
        end
        rst    = 1'b1;
        seg_in = PAT3;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("mid_rst_an", 4, k, {2'b00, an}, 8'h3F);
            chk("mid_rst_seg", 4, k, seg, 8'hFF);
            chk("mid_rst_ft", 4, k, {7'd0, frame_tick}, 8'h00);
        end
        rst = 1'b0;

        // Reset restored visibility and digit 0; flash still high, so the
        // second frame goes blank again.
        check_frame(PAT3, 3'd7, 1'b1, 7, 0, 48'd0);
        check_frame(PAT3, 3'd7, 1'b0, 7, 0, 48'd0);
        flash = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
